busca_instrucao: RTL and testbench

Instruction-fetch stage of the MIPS simulator datapath, directly upstream of the control unit. Holds the program counter, fetches one 32-bit word per instruction from instruction memory over a request/ready handshake, latches it in an instruction register and presents the decoded fields (`opCode` feeding the control unit, plus register, immediate and jump fields). On each downstream `avanca` it computes the next PC from the control unit's `jump` and `branch` signals and the ALU `zero` flag.

---
 rtl/busca_instrucao_pkg.sv | 37 +++
 rtl/busca_instrucao_if.sv | 22 ++
 rtl/busca_instrucao_calc_proximo_pc.sv | 29 ++
 rtl/busca_instrucao.sv | 113 +++++++++++
 tb/tb_busca_instrucao.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/busca_instrucao_pkg.sv
// Shared MIPS datapath definitions: fetch FSM states,
// opcode constants and instruction field positions.
package mips_pkg;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        BUSCA  = 2'd1,
        VALIDO = 2'd2
    } estado_t;

    localparam logic [5:0] OP_TIPO_R = 6'd0;
    localparam logic [5:0] OP_J      = 6'd2;
    localparam logic [5:0] OP_BEQ    = 6'd4;
    localparam logic [5:0] OP_LW     = 6'd35;
    localparam logic [5:0] OP_SW     = 6'd43;

    localparam int OPC_MSB   = 31;
    localparam int OPC_LSB   = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMED_MSB  = 15;
    localparam int JADDR_MSB = 25;

    // Branch offset is in words: sign-extend and scale to bytes.
    function automatic logic [31:0] desloc_branch(input logic [15:0] imed);
        return {{14{imed[15]}}, imed, 2'b00};
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// Instruction memory request/ready channel between the
// fetch stage (master) and instruction memory (slave).
interface busca_instrucao_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_data
    );
endinterface

// File: rtl/busca_instrucao_calc_proximo_pc.sv
// Next-PC selection: jump, taken branch, or sequential.
// Purely combinational.
module calc_proximo_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_mais4,
    input  logic [15:0] imediato,
    input  logic [25:0] endereco_jump,
    input  logic        jump,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] proximo_pc
);

    logic [31:0] alvo_branch;

    assign alvo_branch = pc_mais4 + desloc_branch(imediato);

    // Jump outranks a taken branch when both are flagged.
    always_comb begin
        proximo_pc = pc_mais4;
        priority case (1'b1)
            jump:          proximo_pc = {pc_mais4[31:28], endereco_jump, 2'b00};
            branch & zero: proximo_pc = alvo_branch;
            default:       proximo_pc = pc_mais4;
        endcase
    end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction-fetch stage: PC, instruction register and
// request/ready fetch FSM feeding the control unit.
module busca_instrucao
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst,
    busca_instrucao_if.master         imem,
    input  logic                      avanca,
    input  logic                      jump,
    input  logic                      branch,
    input  logic                      zero,
    output logic                      instr_valida,
    output logic [5:0]                opCode,
    output logic [4:0]                rs,
    output logic [4:0]                rt,
    output logic [4:0]                rd,
    output logic [4:0]                shamt,
    output logic [5:0]                funct,
    output logic [15:0]               imediato,
    output logic [25:0]               endereco_jump,
    output logic [31:0]               pc,
    output logic [31:0]               pc_mais4
);

    localparam logic [31:0] PC_RESET = {PC_INICIAL[31:2], 2'b00};

    estado_t     estado;
    estado_t     prox_estado;
    logic [31:0] ir;
    logic [31:0] proximo_pc;
    logic        carrega_ir;
    logic        atualiza_pc;
    logic        req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= INICIO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= PC_RESET;
            ir <= '0;
        end else begin
            if (carrega_ir) begin
                ir <= imem.imem_data;
            end
            if (atualiza_pc) begin
                pc <= proximo_pc;
            end
        end
    end

    always_comb begin
        prox_estado  = estado;
        req          = 1'b0;
        instr_valida = 1'b0;
        carrega_ir   = 1'b0;
        atualiza_pc  = 1'b0;
        unique case (estado)
            INICIO: begin
                prox_estado = BUSCA;
            end
            BUSCA: begin
                req = 1'b1;
                if (imem.imem_ready) begin
                    carrega_ir  = 1'b1;
                    prox_estado = VALIDO;
                end
            end
            VALIDO: begin
                instr_valida = 1'b1;
                if (avanca) begin
                    atualiza_pc = 1'b1;
                    prox_estado = BUSCA;
                end
            end
            default: begin
                prox_estado = INICIO;
            end
        endcase
    end

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;
    assign pc_mais4       = pc + 32'd4;

    assign opCode        = ir[OPC_MSB:OPC_LSB];
    assign rs            = ir[RS_MSB:RS_LSB];
    assign rt            = ir[RT_MSB:RT_LSB];
    assign rd            = ir[RD_MSB:RD_LSB];
    assign shamt         = ir[SHAMT_MSB:SHAMT_LSB];
    assign funct         = ir[FUNCT_MSB:FUNCT_LSB];
    assign imediato      = ir[IMED_MSB:0];
    assign endereco_jump = ir[JADDR_MSB:0];

    calc_proximo_pc u_calc_proximo_pc (
        .pc_mais4      (pc_mais4),
        .imediato      (imediato),
        .endereco_jump (endereco_jump),
        .jump          (jump),
        .branch        (branch),
        .zero          (zero),
        .proximo_pc    (proximo_pc)
    );

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for the fetch stage: a program table walked with
// zero-wait memory plus hand sequences for stalls, holds and reset.
module tb_busca_instrucao;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    logic avanca = 1'b0;
    logic jump = 1'b0;
    logic branch = 1'b0;
    logic zero = 1'b0;

    always #5 clk = ~clk;

    busca_instrucao_if mem_a ();
    busca_instrucao_if mem_b ();

    logic        valida_a, valida_b;
    logic [5:0]  op_a, op_b, funct_a, funct_b;
    logic [4:0]  rs_a, rs_b, rt_a, rt_b, rd_a, rd_b, sh_a, sh_b;
    logic [15:0] imed_a, imed_b;
    logic [25:0] jaddr_a, jaddr_b;
    logic [31:0] pc_a, pc_b, pc4_a, pc4_b;

    busca_instrucao dut_a (
        .clk(clk), .rst(rst), .imem(mem_a),
        .avanca(avanca), .jump(jump), .branch(branch), .zero(zero),
        .instr_valida(valida_a), .opCode(op_a), .rs(rs_a), .rt(rt_a),
        .rd(rd_a), .shamt(sh_a), .funct(funct_a), .imediato(imed_a),
        .endereco_jump(jaddr_a), .pc(pc_a), .pc_mais4(pc4_a)
    );

    busca_instrucao #(.PC_INICIAL(32'h0000_0103)) dut_b (
        .clk(clk), .rst(rst_b), .imem(mem_b),
        .avanca(avanca), .jump(jump), .branch(branch), .zero(zero),
        .instr_valida(valida_b), .opCode(op_b), .rs(rs_b), .rt(rt_b),
        .rd(rd_b), .shamt(sh_b), .funct(funct_b), .imediato(imed_b),
        .endereco_jump(jaddr_b), .pc(pc_b), .pc_mais4(pc4_b)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        j;
        logic        b;
        logic        z;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imed;
        logic [31:0] prox;
    } vec_t;

    vec_t tab[10];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nome, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_a.imem_ready = 1'b0;
        mem_a.imem_data  = '0;
        mem_b.imem_ready = 1'b0;
        mem_b.imem_data  = '0;

        tab[0] = '{32'h00, 32'h8C22_0004, 0, 0, 0, OP_LW,  1, 2, 16'h0004, 32'h04};
        tab[1] = '{32'h04, 32'h0000_0000, 0, 0, 0, OP_TIPO_R, 0, 0, 16'h0000, 32'h08};
        tab[2] = '{32'h08, 32'h0800_0010, 1, 0, 0, OP_J,   0, 0, 16'h0010, 32'h40};
        tab[3] = '{32'h40, 32'h0800_0008, 1, 0, 0, OP_J,   0, 0, 16'h0008, 32'h20};
        tab[4] = '{32'h20, 32'h1000_FFFE, 0, 1, 1, OP_BEQ, 0, 0, 16'hFFFE, 32'h1C};
        tab[5] = '{32'h1C, 32'h1000_FFFE, 0, 1, 0, OP_BEQ, 0, 0, 16'hFFFE, 32'h20};
        tab[6] = '{32'h20, 32'h1000_FFFE, 0, 1, 0, OP_BEQ, 0, 0, 16'hFFFE, 32'h24};
        tab[7] = '{32'h24, 32'h1000_0003, 0, 1, 1, OP_BEQ, 0, 0, 16'h0003, 32'h34};
        tab[8] = '{32'h34, 32'h0800_0100, 1, 1, 1, OP_J,   0, 0, 16'h0100, 32'h400};
        tab[9] = '{32'h400, 32'hAC43_0008, 0, 0, 1, OP_SW, 2, 3, 16'h0008, 32'h404};

        repeat (2) tick();
        chk("rst_req", mem_a.imem_req, 0);
        chk("rst_valida", valida_a, 0);
        chk("rst_opcode", op_a, 0);
        chk("rst_imed", imed_a, 0);
        chk("rst_pc", pc_a, 0);
        chk("rst_pc_b", pc_b, 32'h100);
        rst = 1'b0;
        rst_b = 1'b0;
        chk("inicio_req", mem_a.imem_req, 0);
        tick();

        for (int i = 0; i < 10; i++) begin
            chk($sformatf("v%0d_req", i), mem_a.imem_req, 1);
            chk($sformatf("v%0d_addr", i), mem_a.imem_addr, tab[i].pc);
            chk($sformatf("v%0d_nvalida", i), valida_a, 0);
            mem_a.imem_ready = 1'b1;
            mem_a.imem_data  = tab[i].instr;
            tick();
            mem_a.imem_ready = 1'b0;
            mem_a.imem_data  = '0;
            chk($sformatf("v%0d_valida", i), valida_a, 1);
            chk($sformatf("v%0d_opcode", i), op_a, tab[i].op);
            chk($sformatf("v%0d_rs", i), rs_a, tab[i].rs);
            chk($sformatf("v%0d_rt", i), rt_a, tab[i].rt);
            chk($sformatf("v%0d_imed", i), imed_a, tab[i].imed);
            chk($sformatf("v%0d_pc", i), pc_a, tab[i].pc);
            chk($sformatf("v%0d_pc4", i), pc4_a, tab[i].pc + 32'd4);
            chk($sformatf("v%0d_req0", i), mem_a.imem_req, 0);
            avanca = 1'b1;
            jump   = tab[i].j;
            branch = tab[i].b;
            zero   = tab[i].z;
            tick();
            avanca = 1'b0;
            jump   = 1'b0;
            branch = 1'b0;
            zero   = 1'b0;
            chk($sformatf("v%0d_req_prox", i), mem_a.imem_req, 1);
            chk($sformatf("v%0d_prox", i), mem_a.imem_addr, tab[i].prox);
        end

        for (int k = 0; k < 3; k++) begin
            chk("espera_req", mem_a.imem_req, 1);
            chk("espera_addr", mem_a.imem_addr, 32'h404);
            chk("espera_valida", valida_a, 0);
            tick();
        end
        mem_a.imem_ready = 1'b1;
        mem_a.imem_data  = 32'h0085_1020;
        chk("antes_borda_valida", valida_a, 0);
        tick();
        mem_a.imem_data = 32'hFFFF_FFFF;
        chk("espera_fim_valida", valida_a, 1);
        chk("tipo_r_opcode", op_a, OP_TIPO_R);
        chk("tipo_r_rs", rs_a, 4);
        chk("tipo_r_rt", rt_a, 5);
        chk("tipo_r_rd", rd_a, 2);
        chk("tipo_r_shamt", sh_a, 0);
        chk("tipo_r_funct", funct_a, 32);
        chk("tipo_r_jaddr", jaddr_a, 26'h085_1020);

        for (int k = 0; k < 5; k++) begin
            jump   = k[0];
            branch = k[1];
            zero   = ~k[0];
            tick();
            chk("hold_imed", imed_a, 16'h1020);
            chk("hold_rs", rs_a, 4);
            chk("hold_pc", pc_a, 32'h404);
            chk("hold_valida", valida_a, 1);
            chk("hold_req", mem_a.imem_req, 0);
        end
        mem_a.imem_ready = 1'b0;
        mem_a.imem_data  = '0;
        avanca = 1'b1;
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        tick();
        avanca = 1'b0;
        chk("seq_apos_hold", mem_a.imem_addr, 32'h408);

        chk("b_req", mem_b.imem_req, 1);
        chk("b_addr", mem_b.imem_addr, 32'h100);
        mem_b.imem_ready = 1'b1;
        mem_b.imem_data  = 32'h1000_FFBE;
        tick();
        mem_b.imem_ready = 1'b0;
        chk("b_beq_valida", valida_b, 1);
        chk("b_beq_opcode", op_b, OP_BEQ);
        avanca = 1'b1;
        branch = 1'b1;
        zero   = 1'b1;
        tick();
        avanca = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        chk("b_branch_topo", mem_b.imem_addr, 32'hFFFF_FFFC);
        chk("b_pc4_wrap", pc4_b, 32'h0);
        chk("a_ignora_avanca", mem_a.imem_addr, 32'h408);
        mem_b.imem_ready = 1'b1;
        mem_b.imem_data  = 32'h0;
        tick();
        mem_b.imem_ready = 1'b0;
        avanca = 1'b1;
        tick();
        avanca = 1'b0;
        chk("b_wrap_zero", mem_b.imem_addr, 32'h0);
        mem_b.imem_ready = 1'b1;
        mem_b.imem_data  = 32'h0800_0010;
        tick();
        mem_b.imem_ready = 1'b0;
        avanca = 1'b1;
        jump   = 1'b1;
        tick();
        avanca = 1'b0;
        jump   = 1'b0;
        chk("b_busca_40", mem_b.imem_addr, 32'h40);
        chk("b_req_40", mem_b.imem_req, 1);

        mem_b.imem_ready = 1'b1;
        mem_b.imem_data  = 32'h8C22_0004;
        #1 rst_b = 1'b1;
        #1;
        chk("rst_async_req", mem_b.imem_req, 0);
        chk("rst_async_pc", pc_b, 32'h100);
        chk("rst_async_valida", valida_b, 0);
        tick();
        rst_b = 1'b0;
        chk("pos_rst_inicio_req", mem_b.imem_req, 0);
        chk("pos_rst_inicio_valida", valida_b, 0);
        tick();
        chk("pos_rst_req", mem_b.imem_req, 1);
        chk("pos_rst_addr", mem_b.imem_addr, 32'h100);
        chk("pos_rst_nvalida", valida_b, 0);
        tick();
        mem_b.imem_ready = 1'b0;
        chk("pos_rst_valida", valida_b, 1);
        chk("pos_rst_opcode", op_b, OP_LW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
